// File: rtl/mac_pkg.sv
// mac_pkg -- definitions shared by the MAC sequencing controller and its users.
//   * Default element/accumulator/address widths for the MAC datapath.
//   * Controller FSM state encoding.
package mac_pkg;

  localparam int MAC_DATA_WIDTH   = 16;  // S5.10 data elements
  localparam int MAC_WEIGHT_WIDTH = 8;   // S1.6 weight elements
  localparam int MAC_ACCUM_WIDTH  = 32;  // accumulator / captured result
  localparam int MAC_ADDR_WIDTH   = 8;   // operand buffer address

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_OUT     = 3'd4
  } mac_state_e;

  function automatic logic state_is_busy(mac_state_e s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl -- sequences one dot product through an external MAC.
//
// On an accepted start the controller walks N element pairs out of two operand
// buffers (1-cycle read latency), drives the MAC enable/clear in step with the
// returning read data, captures the final accumulator and presents it with a
// valid/ready handshake. It does no arithmetic on the data itself.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start             request one dot product (honoured only when idle)
//   vec_len           element count N (0..2^ADDR_WIDTH)
//   data_base         data buffer start address
//   weight_base       weight buffer start address
//   rd_en             read strobe for both operand buffers
//   data_addr         data buffer read address
//   weight_addr       weight buffer read address
//   mac_enable        MAC enable (rd_en delayed one cycle)
//   mac_clear         MAC accumulator clear, with element 0 only
//   mac_accum_in      MAC accumulator output
//   mac_valid_in      MAC accumulator-valid output
//   result            captured dot product
//   result_valid      result available
//   result_ready      consumer accepts result
//   busy              controller not idle
//   err               sticky: MAC valid was low at capture
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH   = MAC_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = MAC_WEIGHT_WIDTH,
  parameter int ACCUM_WIDTH  = MAC_ACCUM_WIDTH,
  parameter int ADDR_WIDTH   = MAC_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH:0]    vec_len,
  input  logic [ADDR_WIDTH-1:0]  data_base,
  input  logic [ADDR_WIDTH-1:0]  weight_base,
  output logic                   rd_en,
  output logic [ADDR_WIDTH-1:0]  data_addr,
  output logic [ADDR_WIDTH-1:0]  weight_addr,
  output logic                   mac_enable,
  output logic                   mac_clear,
  input  logic [ACCUM_WIDTH-1:0] mac_accum_in,
  input  logic                   mac_valid_in,
  output logic [ACCUM_WIDTH-1:0] result,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   busy,
  output logic                   err
);

  // The controller never touches the element data, but the accumulator must
  // be able to hold a full product or the captured result is meaningless.
  if (ACCUM_WIDTH < DATA_WIDTH + WEIGHT_WIDTH) begin : g_width_check
    $error("mac_seq_ctrl: ACCUM_WIDTH narrower than one data x weight product");
  end

  mac_state_e             state_q, state_d;
  logic [ADDR_WIDTH:0]    len_q, len_d;
  logic [ADDR_WIDTH-1:0]  dbase_q, dbase_d;
  logic [ADDR_WIDTH-1:0]  wbase_q, wbase_d;
  logic [ADDR_WIDTH:0]    idx_q, idx_d;
  logic [ADDR_WIDTH:0]    idx_nxt;
  logic                   rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]  data_addr_q, data_addr_d;
  logic [ADDR_WIDTH-1:0]  weight_addr_q, weight_addr_d;
  logic                   mac_enable_q, mac_enable_d;
  logic                   mac_clear_q, mac_clear_d;
  logic [ACCUM_WIDTH-1:0] result_q, result_d;
  logic                   result_valid_q, result_valid_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;

  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    dbase_d        = dbase_q;
    wbase_d        = wbase_q;
    idx_d          = idx_q;
    rd_en_d        = rd_en_q;
    data_addr_d    = data_addr_q;
    weight_addr_d  = weight_addr_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    err_d          = err_q;

    // Read data returns one cycle after rd_en, so the MAC enable simply
    // trails the read strobe; the clear rides on the element-0 read.
    mac_enable_d = rd_en_q;
    mac_clear_d  = rd_en_q && (state_q == ST_ISSUE) && (idx_q == '0);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (vec_len != '0) begin
            len_d         = vec_len;
            dbase_d       = data_base;
            wbase_d       = weight_base;
            idx_d         = '0;
            rd_en_d       = 1'b1;
            data_addr_d   = data_base;
            weight_addr_d = weight_base;
            state_d       = ST_ISSUE;
          end else begin
            // Empty vector: nothing to read, answer immediately with zero.
            result_d       = '0;
            result_valid_d = 1'b1;
            state_d        = ST_OUT;
          end
        end
      end

      ST_ISSUE: begin
        if (idx_q == len_q - 1'b1) begin
          rd_en_d = 1'b0;
          state_d = ST_DRAIN;
        end else begin
          // Address sums wrap around the buffer by truncation.
          idx_d         = idx_nxt;
          data_addr_d   = dbase_q + idx_nxt[ADDR_WIDTH-1:0];
          weight_addr_d = wbase_q + idx_nxt[ADDR_WIDTH-1:0];
        end
      end

      // Last element's mac_enable is high during this cycle.
      ST_DRAIN: state_d = ST_CAPTURE;

      ST_CAPTURE: begin
        result_d       = mac_accum_in;
        result_valid_d = 1'b1;
        if (!mac_valid_in) err_d = 1'b1;
        state_d        = ST_OUT;
      end

      ST_OUT: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = state_is_busy(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      dbase_q        <= '0;
      wbase_q        <= '0;
      idx_q          <= '0;
      rd_en_q        <= 1'b0;
      data_addr_q    <= '0;
      weight_addr_q  <= '0;
      mac_enable_q   <= 1'b0;
      mac_clear_q    <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      dbase_q        <= dbase_d;
      wbase_q        <= wbase_d;
      idx_q          <= idx_d;
      rd_en_q        <= rd_en_d;
      data_addr_q    <= data_addr_d;
      weight_addr_q  <= weight_addr_d;
      mac_enable_q   <= mac_enable_d;
      mac_clear_q    <= mac_clear_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
    end
  end

  assign rd_en        = rd_en_q;
  assign data_addr    = data_addr_q;
  assign weight_addr  = weight_addr_q;
  assign mac_enable   = mac_enable_q;
  assign mac_clear    = mac_clear_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule
